// File: rtl/synth_keys_pkg.sv
// Shared scan-code constants and FSM state type for the PS/2 piano-row note decoder.
package synth_keys_pkg;

  localparam int DEF_NUM_KEYS = 13;

  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;

  // Piano-row keys, listed in note order C .. C'
  localparam logic [7:0] SC_A = 8'h1C;
  localparam logic [7:0] SC_W = 8'h1D;
  localparam logic [7:0] SC_S = 8'h1B;
  localparam logic [7:0] SC_E = 8'h24;
  localparam logic [7:0] SC_D = 8'h23;
  localparam logic [7:0] SC_F = 8'h2B;
  localparam logic [7:0] SC_T = 8'h2C;
  localparam logic [7:0] SC_G = 8'h34;
  localparam logic [7:0] SC_Y = 8'h35;
  localparam logic [7:0] SC_H = 8'h33;
  localparam logic [7:0] SC_U = 8'h3C;
  localparam logic [7:0] SC_J = 8'h3B;
  localparam logic [7:0] SC_K = 8'h42;

  typedef enum logic [1:0] {IDLE, ACK, WAIT_LOW, EMIT} state_e;

endpackage

// File: rtl/ps2_keymap.sv
// Combinational lookup from a set-2 scan byte to a piano note index.
module ps2_keymap
  import synth_keys_pkg::*;
#(
  parameter int IDX_W = 4
) (
  input  logic [7:0]       scan_code_i,
  output logic             hit_o,
  output logic [IDX_W-1:0] idx_o
);

  always_comb begin
    hit_o = 1'b1;
    idx_o = '0;
    case (scan_code_i)
      SC_A:    idx_o = IDX_W'(0);
      SC_W:    idx_o = IDX_W'(1);
      SC_S:    idx_o = IDX_W'(2);
      SC_E:    idx_o = IDX_W'(3);
      SC_D:    idx_o = IDX_W'(4);
      SC_F:    idx_o = IDX_W'(5);
      SC_T:    idx_o = IDX_W'(6);
      SC_G:    idx_o = IDX_W'(7);
      SC_Y:    idx_o = IDX_W'(8);
      SC_H:    idx_o = IDX_W'(9);
      SC_U:    idx_o = IDX_W'(10);
      SC_J:    idx_o = IDX_W'(11);
      SC_K:    idx_o = IDX_W'(12);
      default: begin
        hit_o = 1'b0;
        idx_o = '0;
      end
    endcase
  end

endmodule

// File: rtl/ps2_note_decoder.sv
// PS/2 scan bytes -> note-on/note-off events plus held-key bitmap.
// Define TYPEMATIC_FILTER_EN to suppress auto-repeat makes and breaks of keys not held.
module ps2_note_decoder
  import synth_keys_pkg::*;
#(
  parameter int NUM_KEYS    = DEF_NUM_KEYS,
  parameter int IDX_W       = 4,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                scan_ready,
  input  logic [7:0]          scan_code,
  output logic                read,
  output logic                note_valid,
  input  logic                note_ready,
  output logic [IDX_W-1:0]    note_idx,
  output logic                note_on,
  output logic [NUM_KEYS-1:0] held_keys
);

  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  state_e              state_q;
  logic [7:0]          byte_q;
  logic                brk_q, ext_q;
  logic                pend_q, pend_on_q;
  logic [IDX_W-1:0]    pend_idx_q;
  logic [TW-1:0]       timer_q;
  logic                read_q, valid_q, on_q;
  logic [IDX_W-1:0]    idx_q;
  logic [NUM_KEYS-1:0] held_q;

  logic                brk_d, ext_d, pend_d;
  logic                hit_s;
  logic [IDX_W-1:0]    map_idx_s;
  logic                timer_done_s;

  ps2_keymap #(.IDX_W(IDX_W)) u_keymap (
    .scan_code_i (byte_q),
    .hit_o       (hit_s),
    .idx_o       (map_idx_s)
  );

  assign timer_done_s = (timer_q == TW'(ACK_TIMEOUT));

  // Prefix tracking and event decision for the byte latched in IDLE
  always_comb begin
    brk_d  = 1'b0;
    ext_d  = 1'b0;
    pend_d = 1'b0;
    if (byte_q == SC_BREAK) begin
      brk_d = 1'b1;
      ext_d = ext_q;
    end else if (byte_q == SC_EXT) begin
      brk_d = brk_q;
      ext_d = 1'b1;
    end else if (ext_q) begin
      pend_d = 1'b0;
    end else if (hit_s) begin
`ifdef TYPEMATIC_FILTER_EN
      pend_d = brk_q ? held_q[map_idx_s] : !held_q[map_idx_s];
`else
      pend_d = 1'b1;
`endif
    end else begin
      pend_d = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      byte_q     <= 8'h00;
      brk_q      <= 1'b0;
      ext_q      <= 1'b0;
      pend_q     <= 1'b0;
      pend_on_q  <= 1'b0;
      pend_idx_q <= '0;
      timer_q    <= '0;
      read_q     <= 1'b0;
      valid_q    <= 1'b0;
      on_q       <= 1'b0;
      idx_q      <= '0;
      held_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (scan_ready) begin
            byte_q  <= scan_code;
            read_q  <= 1'b1;
            state_q <= ACK;
          end
        end
        ACK: begin
          read_q     <= 1'b0;
          brk_q      <= brk_d;
          ext_q      <= ext_d;
          pend_q     <= pend_d;
          pend_on_q  <= !brk_q;
          pend_idx_q <= map_idx_s;
          timer_q    <= '0;
          state_q    <= WAIT_LOW;
        end
        // Wait for the receiver to drop scan_ready; a stuck line is abandoned after the timeout
        WAIT_LOW: begin
          if (!scan_ready || timer_done_s) begin
            if (pend_q) begin
              valid_q            <= 1'b1;
              idx_q              <= pend_idx_q;
              on_q               <= pend_on_q;
              held_q[pend_idx_q] <= pend_on_q;
              state_q            <= EMIT;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        EMIT: begin
          if (note_ready) begin
            valid_q <= 1'b0;
            pend_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign read       = read_q;
  assign note_valid = valid_q;
  assign note_idx   = idx_q;
  assign note_on    = on_q;
  assign held_keys  = held_q;

endmodule

// File: tb/tb_ps2_note_decoder.sv
// Self-checking bench: directed scenarios plus randomized byte streams against a key-level model.
module tb_ps2_note_decoder;

  localparam int ACK_TIMEOUT = 255;

  logic        clock, reset, scan_ready, read, note_valid, note_ready, note_on;
  logic [7:0]  scan_code;
  logic [3:0]  note_idx;
  logic [12:0] held_keys;

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int read_hits = 0;
  bit rand_ready = 0;

  logic [7:0] keys [13] = '{8'h1C, 8'h1D, 8'h1B, 8'h24, 8'h23, 8'h2B, 8'h2C,
                            8'h34, 8'h35, 8'h33, 8'h3C, 8'h3B, 8'h42};
  bit m_brk, m_ext;
  bit m_held [13];
  int exp_q[$];
  int got_q[$];

  ps2_note_decoder #(.NUM_KEYS(13), .IDX_W(4), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
    .clock(clock), .reset(reset), .scan_ready(scan_ready), .scan_code(scan_code),
    .read(read), .note_valid(note_valid), .note_ready(note_ready),
    .note_idx(note_idx), .note_on(note_on), .held_keys(held_keys)
  );

  initial clock = 1'b0;
  always #10 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Inputs change only just after posedge, so a handshake seen here completes at the next edge
  always @(negedge clock) begin
    if (!reset && note_valid === 1'b1 && note_ready === 1'b1)
      got_q.push_back(int'(note_idx) * 2 + int'(note_on));
    if (!reset && read === 1'b1)
      read_hits++;
  end

  function automatic int key_index(input logic [7:0] b);
    for (int i = 0; i < 13; i++) if (keys[i] == b) return i;
    return -1;
  endfunction

  function automatic logic [12:0] model_held();
    logic [12:0] v = 13'h0000;
    for (int i = 0; i < 13; i++) v[i] = m_held[i];
    return v;
  endfunction

  task automatic model_byte(input logic [7:0] b);
    int k;
    bit emit;
    if (b == 8'hF0) m_brk = 1'b1;
    else if (b == 8'hE0) m_ext = 1'b1;
    else begin
      k = key_index(b);
      if (!m_ext && k >= 0) begin
        emit = 1'b1;
`ifdef TYPEMATIC_FILTER_EN
        if (!m_brk && m_held[k]) emit = 1'b0;
        if (m_brk && !m_held[k]) emit = 1'b0;
`endif
        if (emit) begin
          exp_q.push_back(k * 2 + (m_brk ? 0 : 1));
          m_held[k] = !m_brk;
        end
      end
      m_brk = 1'b0;
      m_ext = 1'b0;
    end
  endtask

  task automatic model_clear();
    m_brk = 1'b0;
    m_ext = 1'b0;
    for (int i = 0; i < 13; i++) m_held[i] = 1'b0;
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic wait_ack(input logic [7:0] b);
    bit seen = 1'b0;
    for (int n = 0; n < 600 && !seen; n++) begin
      @(negedge clock);
      if (read === 1'b1) seen = 1'b1;
      else begin
        @(posedge clock); #1;
        if (rand_ready) note_ready = ($urandom_range(0, 3) != 0);
      end
    end
    checks++;
    if (!seen) $display("FAIL ack_wait byte %h: read never pulsed within 600 cycles", b);
    else passes++;
    @(posedge clock); #1;
    scan_ready = 1'b0;
    if (seen) model_byte(b);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clock); #1;
    scan_code  = b;
    scan_ready = 1'b1;
    wait_ack(b);
  endtask

  task automatic drain();
    rand_ready = 1'b0;
    @(posedge clock); #1;
    note_ready = 1'b1;
    repeat (10) @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    checks++;
    if ({read, note_valid, note_idx, note_on} !== 7'd0 || held_keys !== 13'h0000)
      $display("FAIL reset_outputs got read=%b valid=%b idx=%0d on=%b held=%h, expected all 0",
               read, note_valid, note_idx, note_on, held_keys);
    else passes++;
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  task automatic test_press();
    int r0;
    model_clear();
    note_ready = 1'b1;
    r0 = read_hits;
    send_byte(8'h1C);
    @(negedge clock);
    checks++;
    if (note_valid !== 1'b0) $display("FAIL press_latency_early got valid=%b, expected 0", note_valid);
    else passes++;
    @(negedge clock);
    checks++;
    if (note_valid !== 1'b1) $display("FAIL press_latency got valid=%b, expected 1", note_valid);
    else passes++;
    drain();
    checks++;
    if (read_hits - r0 != 1) $display("FAIL press_read_width got %0d read cycles, expected 1", read_hits - r0);
    else passes++;
    checks++;
    if (got_q.size() != 1 || got_q[0] != 1)
      $display("FAIL press_event got %0d events (first %0d), expected 1 event code 1", got_q.size(),
               got_q.size() > 0 ? got_q[0] : -1);
    else passes++;
    checks++;
    if (held_keys !== 13'h0001) $display("FAIL press_held got %h, expected 0001", held_keys);
    else passes++;
  endtask

  task automatic test_release();
    got_q.delete(); exp_q.delete();
    send_byte(8'hF0);
    drain();
    checks++;
    if (got_q.size() != 0) $display("FAIL release_prefix_event got %0d events, expected 0", got_q.size());
    else passes++;
    send_byte(8'h1C);
    drain();
    checks++;
    if (got_q.size() != 1 || got_q[0] != 0)
      $display("FAIL release_event got %0d events (first %0d), expected 1 event code 0", got_q.size(),
               got_q.size() > 0 ? got_q[0] : -1);
    else passes++;
    checks++;
    if (held_keys !== 13'h0000) $display("FAIL release_held got %h, expected 0000", held_keys);
    else passes++;
  endtask

  task automatic test_prefix();
    logic [7:0] seq [5] = '{8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75};
    got_q.delete(); exp_q.delete();
    foreach (seq[i]) send_byte(seq[i]);
    drain();
    checks++;
    if (got_q.size() != 0) $display("FAIL prefix_drop got %0d events, expected 0", got_q.size());
    else passes++;
    send_byte(8'h23);
    drain();
    checks++;
    if (got_q.size() != 1 || got_q[0] != 9)
      $display("FAIL prefix_cleared got %0d events (first %0d), expected 1 event code 9 (idx 4 on)",
               got_q.size(), got_q.size() > 0 ? got_q[0] : -1);
    else passes++;
  endtask

  task automatic test_backpressure();
    bit ok, up;
    got_q.delete(); exp_q.delete();
    @(posedge clock); #1;
    note_ready = 1'b0;
    send_byte(8'h42);
    up = 1'b0;
    for (int n = 0; n < 20 && !up; n++) begin
      @(negedge clock);
      if (note_valid === 1'b1) up = 1'b1;
    end
    @(posedge clock); #1;
    scan_code  = 8'h1C;
    scan_ready = 1'b1;
    ok = up;
    repeat (20) begin
      @(negedge clock);
      if (!(note_valid === 1'b1 && note_idx === 4'd12 && note_on === 1'b1 && read === 1'b0)) ok = 1'b0;
    end
    checks++;
    if (!ok) $display("FAIL backpressure_hold got valid=%b idx=%0d on=%b read=%b, expected 1 12 1 0",
                      note_valid, note_idx, note_on, read);
    else passes++;
    @(posedge clock); #1;
    note_ready = 1'b1;
    wait_ack(8'h1C);
    drain();
    checks++;
    if (got_q.size() != 2 || got_q[0] != 25 || got_q[1] != exp_q[1])
      $display("FAIL backpressure_events got %0d events (first %0d), expected 2 starting 25",
               got_q.size(), got_q.size() > 0 ? got_q[0] : -1);
    else passes++;
  endtask

  task automatic test_retrigger();
`ifdef TYPEMATIC_FILTER_EN
    int exp_n = 1;
`else
    int exp_n = 2;
`endif
    bit bad;
    got_q.delete(); exp_q.delete();
    send_byte(8'h1D);
    send_byte(8'h1D);
    drain();
    bad = (got_q.size() != exp_n);
    foreach (got_q[i]) if (got_q[i] != 3) bad = 1'b1;
    checks++;
    if (bad) $display("FAIL retrigger got %0d events, expected %0d events of code 3", got_q.size(), exp_n);
    else passes++;
  endtask

  task automatic test_timeout();
    int t0, t1;
    bit ok0 = 1'b0, ok1 = 1'b0;
    got_q.delete(); exp_q.delete();
    @(posedge clock); #1;
    scan_code  = 8'h00;
    scan_ready = 1'b1;
    for (int n = 0; n < 50 && !ok0; n++) begin
      @(negedge clock);
      if (read === 1'b1) ok0 = 1'b1;
    end
    t0 = cyc;
    @(negedge clock);
    for (int n = 0; n < 1000 && !ok1; n++) begin
      @(negedge clock);
      if (read === 1'b1) ok1 = 1'b1;
    end
    t1 = cyc;
    checks++;
    if (!ok0 || !ok1 || (t1 - t0) < ACK_TIMEOUT + 1 || (t1 - t0) > ACK_TIMEOUT + 5)
      $display("FAIL timeout_exit got reread gap %0d cycles (seen %b %b), expected %0d..%0d",
               t1 - t0, ok0, ok1, ACK_TIMEOUT + 1, ACK_TIMEOUT + 5);
    else passes++;
    @(posedge clock); #1;
    scan_ready = 1'b0;
    model_byte(8'h00);
    drain();
    checks++;
    if (got_q.size() != 0) $display("FAIL timeout_event got %0d events, expected 0", got_q.size());
    else passes++;
  endtask

  task automatic test_reset_in_emit();
    bit up = 1'b0;
    @(posedge clock); #1;
    note_ready = 1'b0;
    send_byte(8'h3C);
    for (int n = 0; n < 20 && !up; n++) begin
      @(negedge clock);
      if (note_valid === 1'b1) up = 1'b1;
    end
    @(posedge clock); #1;
    reset = 1'b1;
    #1;
    checks++;
    if (!up || {read, note_valid, note_idx, note_on} !== 7'd0 || held_keys !== 13'h0000)
      $display("FAIL reset_in_emit got read=%b valid=%b idx=%0d on=%b held=%h (emit seen %b), expected all 0",
               read, note_valid, note_idx, note_on, held_keys, up);
    else passes++;
    model_clear();
    @(posedge clock); #1;
    reset = 1'b0;
    note_ready = 1'b1;
  endtask

  task automatic test_random();
    logic [7:0] unmapped [3] = '{8'h75, 8'h00, 8'h29};
    logic [7:0] b;
    int r;
    bit bad;
    got_q.delete(); exp_q.delete();
    rand_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 9);
      if (r <= 5) b = keys[$urandom_range(0, 12)];
      else if (r <= 7) b = 8'hF0;
      else if (r == 8) b = 8'hE0;
      else b = unmapped[$urandom_range(0, 2)];
      send_byte(b);
    end
    drain();
    bad = (got_q.size() != exp_q.size());
    foreach (exp_q[i]) if (i < got_q.size() && got_q[i] != exp_q[i]) bad = 1'b1;
    checks++;
    if (bad) $display("FAIL random_events got %0d events, expected %0d (or content differs)",
                      got_q.size(), exp_q.size());
    else passes++;
    checks++;
    if (held_keys !== model_held())
      $display("FAIL random_held got %h, expected %h", held_keys, model_held());
    else passes++;
  endtask

  initial begin
    reset      = 1'b1;
    scan_ready = 1'b0;
    scan_code  = 8'h00;
    note_ready = 1'b0;
    test_reset();
    test_press();
    test_release();
    test_prefix();
    test_backpressure();
    test_retrigger();
    test_timeout();
    test_reset_in_emit();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
